// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_adder
// Purpose  : N-digit packed-BCD adder/subtractor, one digit per clock, LSD
//            first, with start/done handshake. Define BCD_SERIAL_ADDER_SAT_EN
//            for saturating results instead of wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   augend,
  input  logic [4*DIGITS-1:0]   addend,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0]    c_S_IDLE = 2'd0;
  localparam logic [1:0]    c_S_RUN  = 2'd1;
  localparam logic [1:0]    c_S_DONE = 2'd2;
  localparam logic [IW-1:0] c_LAST   = IW'(DIGITS - 1);
  localparam logic [W-1:0]  c_ALL9   = {DIGITS{4'h9}};

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_sub;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_busy;
  logic          r_done;
  logic          r_invalid;

  logic [IW+1:0] w_base;
  logic [3:0]    w_a;
  logic [3:0]    w_braw;
  logic [3:0]    w_b;
  logic [4:0]    w_t;
  logic          w_gt9;
  logic [3:0]    w_digit;

  // Subtraction is A + nines'(B) + ~borrow; the final carry then means "no borrow".
  always_comb begin
    w_base  = {r_idx, 2'b00};
    w_a     = r_a[w_base +: 4];
    w_braw  = r_b[w_base +: 4];
    w_b     = r_sub ? (4'd9 - w_braw) : w_braw;
    w_t     = {1'b0, w_a} + {1'b0, w_b} + {4'b0000, r_carry};
    w_gt9   = (w_t > 5'd9);
    w_digit = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          // A start coinciding with the done pulse is dropped, not queued.
          if (start && !r_done) begin
            r_a       <= augend;
            r_b       <= addend;
            r_sub     <= sub;
            r_carry   <= sub ? ~cin : cin;
            r_idx     <= '0;
            r_invalid <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= c_S_RUN;
          end
        end
        c_S_RUN: begin
          r_sum[w_base +: 4] <= w_digit;
          r_carry            <= w_gt9;
          r_invalid          <= r_invalid | (w_a > 4'd9) | (w_braw > 4'd9);
          if (r_idx == c_LAST) begin
            r_cout  <= w_gt9;
            r_state <= c_S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        c_S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_S_IDLE;
`ifdef BCD_SERIAL_ADDER_SAT_EN
          if (!r_sub && r_cout) begin
            r_sum <= c_ALL9;
          end else if (r_sub && !r_cout) begin
            r_sum <= '0;
          end
`endif
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign sum     = r_sum;
  assign cout    = r_cout;
  assign busy    = r_busy;
  assign done    = r_done;
  assign invalid = r_invalid;

endmodule
`default_nettype wire
